ddram_arb: RTL and testbench

Two-master Avalon-MM arbiter that shares one DDRAM port (64-bit data, 29-bit word address, 8-bit burstcount) between the CPU/memory-controller master (A) and the video/framebuffer fetch master (B). It sits between those masters and the DDRAM port and runs in the `clk_sys` domain. Write bursts are kept atomic. Grants alternate round-robin. Read-data beats are returned to the master that issued the read, using an in-order tag FIFO of outstanding read commands.

---
 rtl/ddram_arb.sv | 175 +++++++++++++++++
 tb/tb_ddram_arb.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_arb.sv
// ddram_arb: shares one DDRAM Avalon-MM port between master A (CPU) and master B (video).
// Grants alternate round-robin, write bursts are atomic, read beats are steered by an in-order tag FIFO.
//
// state  | meaning
// IDLE   | no grant; pick a winner among the eligible masters
// CMD    | granted master's command is forwarded to the port
// WBURST | remaining beats of an accepted write burst, grant held
module ddram_arb #(
    parameter int RDQ_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic        a_read,
    input  logic        a_write,
    input  logic [28:0] a_address,
    input  logic [7:0]  a_burstcount,
    input  logic [63:0] a_writedata,
    input  logic [7:0]  a_byteenable,
    output logic        a_waitrequest,
    output logic [63:0] a_readdata,
    output logic        a_readdatavalid,

    input  logic        b_read,
    input  logic        b_write,
    input  logic [28:0] b_address,
    input  logic [7:0]  b_burstcount,
    input  logic [63:0] b_writedata,
    input  logic [7:0]  b_byteenable,
    output logic        b_waitrequest,
    output logic [63:0] b_readdata,
    output logic        b_readdatavalid,

    output logic        ddram_read,
    output logic        ddram_write,
    output logic [28:0] ddram_address,
    output logic [7:0]  ddram_burstcount,
    output logic [63:0] ddram_writedata,
    output logic [7:0]  ddram_byteenable,
    input  logic        ddram_waitrequest,
    input  logic [63:0] ddram_readdata,
    input  logic        ddram_readdatavalid,

    output logic        err_orphan
);
    localparam int PW = $clog2(RDQ_DEPTH);

    typedef enum logic [1:0] {IDLE, CMD, WBURST} state_t;

    state_t        state, state_nx;
    logic          gnt, gnt_nx;
    logic          last_gnt, last_gnt_nx;
    logic [7:0]    wbeats, wbeats_nx;
    logic [7:0]    rbeats;

    logic          tag_own [RDQ_DEPTH];
    logic [7:0]    tag_len [RDQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty, push, pop;
    logic          head_own;
    logic [7:0]    head_len;

    logic          m_read, m_write;
    logic [7:0]    m_burstcount, m_eff;
    logic          a_elig, b_elig;

    assign m_read       = gnt ? b_read       : a_read;
    assign m_write      = gnt ? b_write      : a_write;
    assign m_burstcount = gnt ? b_burstcount : a_burstcount;
    assign m_eff        = (m_burstcount == 8'd0) ? 8'd1 : m_burstcount;

    assign ddram_address    = gnt ? b_address    : a_address;
    assign ddram_burstcount = m_burstcount;
    assign ddram_writedata  = gnt ? b_writedata  : a_writedata;
    assign ddram_byteenable = gnt ? b_byteenable : a_byteenable;

    assign fifo_full  = (count == (PW+1)'(RDQ_DEPTH));
    assign fifo_empty = (count == '0);
    assign a_elig     = a_write | (a_read & ~fifo_full);
    assign b_elig     = b_write | (b_read & ~fifo_full);

    always_comb begin
        state_nx      = state;
        gnt_nx        = gnt;
        last_gnt_nx   = last_gnt;
        wbeats_nx     = wbeats;
        ddram_read    = 1'b0;
        ddram_write   = 1'b0;
        a_waitrequest = 1'b1;
        b_waitrequest = 1'b1;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (a_elig | b_elig) begin
                    gnt_nx      = (a_elig & b_elig) ? ~last_gnt : b_elig;
                    last_gnt_nx = gnt_nx;
                    state_nx    = CMD;
                end
            end
            CMD: begin
                ddram_read    = m_read;
                ddram_write   = m_write;
                a_waitrequest = gnt | ddram_waitrequest;
                b_waitrequest = ~gnt | ddram_waitrequest;
                if (m_read && !ddram_waitrequest) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end else if (m_write && !ddram_waitrequest) begin
                    wbeats_nx = m_eff - 8'd1;
                    state_nx  = (m_eff == 8'd1) ? IDLE : WBURST;
                end else if (!m_read && !m_write) begin
                    state_nx = IDLE;
                end
            end
            WBURST: begin
                // Reads are never forwarded here: an untagged read would desync the return path.
                ddram_write   = m_write;
                a_waitrequest = gnt | ddram_waitrequest;
                b_waitrequest = ~gnt | ddram_waitrequest;
                if (m_write && !ddram_waitrequest) begin
                    wbeats_nx = wbeats - 8'd1;
                    if (wbeats == 8'd1) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign head_own        = tag_own[rd_ptr];
    assign head_len        = tag_len[rd_ptr];
    assign a_readdata      = ddram_readdata;
    assign b_readdata      = ddram_readdata;
    assign a_readdatavalid = ddram_readdatavalid & ~fifo_empty & ~head_own;
    assign b_readdatavalid = ddram_readdatavalid & ~fifo_empty & head_own;
    assign pop             = ddram_readdatavalid & ~fifo_empty & (rbeats + 8'd1 == head_len);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_gnt   <= 1'b1;
            wbeats     <= '0;
            rbeats     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            last_gnt <= last_gnt_nx;
            wbeats   <= wbeats_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
            if (ddram_readdatavalid) begin
                if (fifo_empty)  err_orphan <= 1'b1;
                else if (pop)    rbeats     <= '0;
                else             rbeats     <= rbeats + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            tag_own[wr_ptr] <= gnt;
            tag_len[wr_ptr] <= m_eff;
        end
    end
endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: directed scenarios plus a randomized two-master run against a transaction-level model.
module tb_ddram_arb;
    localparam int DEPTH = 8;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    logic        m_read  [2];
    logic        m_write [2];
    logic [28:0] m_addr  [2];
    logic [7:0]  m_bc    [2];
    logic [63:0] m_wdata [2];
    logic [7:0]  m_be    [2];

    logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
    logic [63:0] a_readdata, b_readdata;
    logic        ddram_read, ddram_write;
    logic [28:0] ddram_address;
    logic [7:0]  ddram_burstcount, ddram_byteenable;
    logic [63:0] ddram_writedata;
    logic        ddram_waitrequest, ddram_readdatavalid;
    logic [63:0] ddram_readdata;
    logic        err_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    ddram_arb #(.RDQ_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_read(m_read[0]), .a_write(m_write[0]), .a_address(m_addr[0]),
        .a_burstcount(m_bc[0]), .a_writedata(m_wdata[0]), .a_byteenable(m_be[0]),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_read(m_read[1]), .b_write(m_write[1]), .b_address(m_addr[1]),
        .b_burstcount(m_bc[1]), .b_writedata(m_wdata[1]), .b_byteenable(m_be[1]),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .ddram_read(ddram_read), .ddram_write(ddram_write), .ddram_address(ddram_address),
        .ddram_burstcount(ddram_burstcount), .ddram_writedata(ddram_writedata),
        .ddram_byteenable(ddram_byteenable), .ddram_waitrequest(ddram_waitrequest),
        .ddram_readdata(ddram_readdata), .ddram_readdatavalid(ddram_readdatavalid),
        .err_orphan(err_orphan)
    );

    task automatic idle_inputs();
        for (int m = 0; m < 2; m++) begin
            m_read[m]  = 1'b0;
            m_write[m] = 1'b0;
            m_addr[m]  = '0;
            m_bc[m]    = 8'd1;
            m_wdata[m] = '0;
            m_be[m]    = 8'hFF;
        end
        ddram_waitrequest   = 1'b0;
        ddram_readdatavalid = 1'b0;
        ddram_readdata      = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        m_read[0]  = 1'b1;
        m_write[1] = 1'b1;
        #1;
        n_tests++;
        if ({a_waitrequest, b_waitrequest} !== 2'b11) begin
            n_fail++; $display("FAIL reset_waitrequest: got %b want 11", {a_waitrequest, b_waitrequest});
        end
        n_tests++;
        if ({ddram_read, ddram_write, a_readdatavalid, b_readdatavalid, err_orphan} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 00000",
                {ddram_read, ddram_write, a_readdatavalid, b_readdatavalid, err_orphan});
        end
        @(negedge clk_sys);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_read();
        logic [63:0] d;
        reset_dut();
        m_read[0] = 1'b1; m_addr[0] = 29'h100; m_bc[0] = 8'd4;
        #1;
        n_tests++;
        if ({ddram_read, a_waitrequest} !== 2'b01) begin
            n_fail++; $display("FAIL single_idle: got rd/wait %b want 01", {ddram_read, a_waitrequest});
        end
        @(negedge clk_sys); #1;
        n_tests++;
        if ({ddram_read, ddram_address, ddram_burstcount, a_waitrequest, b_waitrequest} !==
            {1'b1, 29'h100, 8'd4, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL single_cmd: got rd=%b addr=%h bc=%0d wa=%b wb=%b want 1 100 4 0 1",
                ddram_read, ddram_address, ddram_burstcount, a_waitrequest, b_waitrequest);
        end
        @(negedge clk_sys);
        m_read[0] = 1'b0;
        repeat (9) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            ddram_readdatavalid = 1'b1; ddram_readdata = d;
            #1;
            n_tests++;
            if ({a_readdatavalid, b_readdatavalid} !== 2'b10 || a_readdata !== d) begin
                n_fail++; $display("FAIL single_beat%0d: got va/vb %b data %h want 10 %h",
                    i, {a_readdatavalid, b_readdatavalid}, a_readdata, d);
            end
            @(negedge clk_sys);
        end
        ddram_readdatavalid = 1'b0;
    endtask

    task automatic test_orphan();
        ddram_readdatavalid = 1'b1;
        #1;
        n_tests++;
        if ({a_readdatavalid, b_readdatavalid} !== 2'b00) begin
            n_fail++; $display("FAIL orphan_dropped: got %b want 00", {a_readdatavalid, b_readdatavalid});
        end
        @(negedge clk_sys);
        ddram_readdatavalid = 1'b0;
        #1;
        n_tests++;
        if (err_orphan !== 1'b1) begin
            n_fail++; $display("FAIL orphan_set: got %b want 1", err_orphan);
        end
        repeat (5) @(negedge clk_sys);
        n_tests++;
        if (err_orphan !== 1'b1) begin
            n_fail++; $display("FAIL orphan_sticky: got %b want 1", err_orphan);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int last_c = -1;
        reset_dut();
        m_read[0] = 1'b1; m_addr[0] = 29'h10; m_bc[0] = 8'd1;
        m_read[1] = 1'b1; m_addr[1] = 29'h20; m_bc[1] = 8'd1;
        for (int c = 0; c < 30 && order.size() < 4; c++) begin
            #1;
            if (!a_waitrequest) order.push_back(0);
            if (!b_waitrequest) order.push_back(1);
            if (!a_waitrequest || !b_waitrequest) last_c = c;
            @(negedge clk_sys);
        end
        m_read[0] = 1'b0; m_read[1] = 1'b0;
        n_tests++;
        if (order.size() != 4) begin
            n_fail++; $display("FAIL rr_count: got %0d grants want 4", order.size());
        end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            n_tests++;
            if (order[i] != i % 2) begin
                n_fail++; $display("FAIL rr_order%0d: got %0d want %0d", i, order[i], i % 2);
            end
        end
        n_tests++;
        if (last_c != 7) begin
            n_fail++; $display("FAIL rr_spacing: got last grant cycle %0d want 7", last_c);
        end
        for (int i = 0; i < 4; i++) begin
            ddram_readdatavalid = 1'b1;
            #1;
            n_tests++;
            if ({b_readdatavalid, a_readdatavalid} !== ((i % 2) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL rr_return%0d: got vb/va %b", i, {b_readdatavalid, a_readdatavalid});
            end
            @(negedge clk_sys);
        end
        ddram_readdatavalid = 1'b0;
    endtask

    task automatic test_atomic_write();
        int beats = 0;
        int last_c = -1;
        int a_c = -1;
        reset_dut();
        m_addr[1] = 29'h200; m_bc[1] = 8'd8;
        m_addr[0] = 29'h333; m_bc[0] = 8'd1;
        for (int c = 0; c < 60 && a_c < 0; c++) begin
            ddram_waitrequest = c[0];
            m_write[1] = (beats < 8);
            m_wdata[1] = 64'hB000 + 64'(beats);
            m_read[0]  = (beats >= 1);
            #1;
            if (m_read[0] && !a_waitrequest) begin
                a_c = c;
                n_tests++;
                if (beats < 8) begin
                    n_fail++; $display("FAIL atomic_a_early: got A grant after %0d beats want 8", beats);
                end
            end
            if (m_write[1] && !b_waitrequest) begin
                n_tests++;
                if (ddram_write !== 1'b1 || ddram_writedata !== 64'hB000 + 64'(beats) || a_waitrequest !== 1'b1) begin
                    n_fail++; $display("FAIL atomic_beat%0d: got wr=%b data=%h wa=%b want 1 %h 1",
                        beats, ddram_write, ddram_writedata, a_waitrequest, 64'hB000 + 64'(beats));
                end
                beats++;
                if (beats == 8) last_c = c;
            end
            if (last_c >= 0 && c == last_c + 1) begin
                n_tests++;
                if ({ddram_read, ddram_write, a_waitrequest, b_waitrequest} !== 4'b0011) begin
                    n_fail++; $display("FAIL atomic_idle_gap: got %b want 0011",
                        {ddram_read, ddram_write, a_waitrequest, b_waitrequest});
                end
            end
            if (last_c >= 0 && c == last_c + 2) begin
                n_tests++;
                if (ddram_read !== 1'b1 || ddram_address !== 29'h333) begin
                    n_fail++; $display("FAIL atomic_a_issue: got rd=%b addr=%h want 1 333", ddram_read, ddram_address);
                end
            end
            @(negedge clk_sys);
        end
        m_read[0] = 1'b0; m_write[1] = 1'b0; ddram_waitrequest = 1'b0;
        n_tests++;
        if (beats != 8 || a_c < 0) begin
            n_fail++; $display("FAIL atomic_done: got beats=%0d a_cycle=%0d want 8 and A granted", beats, a_c);
        end
        ddram_readdatavalid = 1'b1;
        #1;
        n_tests++;
        if ({b_readdatavalid, a_readdatavalid} !== 2'b01) begin
            n_fail++; $display("FAIL atomic_return: got vb/va %b want 01", {b_readdatavalid, a_readdatavalid});
        end
        @(negedge clk_sys);
        ddram_readdatavalid = 1'b0;
    endtask

    task automatic test_fifo_full();
        int acc = 0;
        int b_acc = 0;
        bit a9 = 0;
        reset_dut();
        m_read[0] = 1'b1; m_bc[0] = 8'd1;
        for (int c = 0; c < 40 && acc < DEPTH; c++) begin
            #1;
            if (!a_waitrequest) acc++;
            @(negedge clk_sys);
        end
        n_tests++;
        if (acc != DEPTH) begin
            n_fail++; $display("FAIL full_fill: got %0d reads want %0d", acc, DEPTH);
        end
        for (int c = 0; c < 8; c++) begin
            m_write[1] = (b_acc == 0);
            #1;
            if (!a_waitrequest) a9 = 1;
            if (m_write[1] && !b_waitrequest) b_acc++;
            @(negedge clk_sys);
        end
        m_write[1] = 1'b0;
        n_tests++;
        if (a9 || b_acc != 1) begin
            n_fail++; $display("FAIL full_block: got a_granted=%0d b_writes=%0d want 0 1", a9, b_acc);
        end
        ddram_readdatavalid = 1'b1;
        #1;
        n_tests++;
        if (a_readdatavalid !== 1'b1 || !a_waitrequest) begin
            n_fail++; $display("FAIL full_pop: got va=%b wa=%b want 1 1", a_readdatavalid, a_waitrequest);
        end
        @(negedge clk_sys);
        ddram_readdatavalid = 1'b0;
        for (int c = 0; c < 6 && !a9; c++) begin
            #1;
            if (!a_waitrequest) a9 = 1;
            @(negedge clk_sys);
        end
        m_read[0] = 1'b0;
        n_tests++;
        if (!a9) begin
            n_fail++; $display("FAIL full_regrant: got no grant want A read granted");
        end
        for (int i = 0; i < DEPTH; i++) begin
            ddram_readdatavalid = 1'b1;
            #1;
            n_tests++;
            if ({b_readdatavalid, a_readdatavalid} !== 2'b01) begin
                n_fail++; $display("FAIL full_drain%0d: got vb/va %b want 01", i, {b_readdatavalid, a_readdatavalid});
            end
            @(negedge clk_sys);
        end
        ddram_readdatavalid = 1'b0;
    endtask

    task automatic test_reset_midburst();
        int beats = 0;
        reset_dut();
        ddram_readdatavalid = 1'b1;
        m_write[1] = 1'b1; m_bc[1] = 8'd8; m_addr[1] = 29'h400;
        @(negedge clk_sys);
        ddram_readdatavalid = 1'b0;
        for (int c = 0; c < 20 && beats < 3; c++) begin
            #1;
            if (!b_waitrequest) beats++;
            @(negedge clk_sys);
        end
        n_tests++;
        if (err_orphan !== 1'b1 || beats != 3) begin
            n_fail++; $display("FAIL midburst_setup: got err=%b beats=%0d want 1 3", err_orphan, beats);
        end
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({a_waitrequest, b_waitrequest, ddram_write, ddram_read, err_orphan} !== 5'b11000) begin
            n_fail++; $display("FAIL midburst_reset: got %b want 11000",
                {a_waitrequest, b_waitrequest, ddram_write, ddram_read, err_orphan});
        end
        @(negedge clk_sys);
        idle_inputs();
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_random();
        int         pend  [2];
        logic       is_wr [2];
        int         wr_owner = -1;
        int         q_len[$];
        int         q_own[$];
        int         head_done = 0;
        logic [1:0] acc;
        logic [63:0] rd;
        logic       rv;
        int         own;
        bit         done = 0;
        pend[0] = 0; pend[1] = 0; is_wr[0] = 1'b0; is_wr[1] = 1'b0;
        reset_dut();
        for (int c = 0; c < 3000 && !done; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (pend[m] == 0 && c < 2000 && $urandom_range(0, 2) == 0) begin
                    is_wr[m]   = 1'($urandom_range(0, 1));
                    m_bc[m]    = 8'($urandom_range(0, 4));
                    pend[m]    = (m_bc[m] == 8'd0) ? 1 : int'(m_bc[m]);
                    m_addr[m]  = 29'($urandom);
                    m_be[m]    = 8'($urandom);
                    m_wdata[m] = {$urandom, $urandom};
                end
                m_read[m]  = (pend[m] != 0) && !is_wr[m];
                m_write[m] = (pend[m] != 0) && is_wr[m];
            end
            ddram_waitrequest   = ($urandom_range(0, 3) == 0);
            rv                  = (q_len.size() != 0) && ($urandom_range(0, 2) != 0);
            rd                  = {$urandom, $urandom};
            ddram_readdatavalid = rv;
            ddram_readdata      = rd;
            #1;
            acc = {(m_read[1] | m_write[1]) & ~b_waitrequest, (m_read[0] | m_write[0]) & ~a_waitrequest};
            n_tests++;
            if (acc == 2'b11) begin
                n_fail++; $display("FAIL rnd_single_grant: got both accepted at cycle %0d", c);
            end
            n_tests++;
            if (((ddram_read | ddram_write) & ~ddram_waitrequest) !== (acc != 2'b00)) begin
                n_fail++; $display("FAIL rnd_port_accept: got port=%b masters=%b at cycle %0d",
                    (ddram_read | ddram_write) & ~ddram_waitrequest, acc, c);
            end
            for (int m = 0; m < 2; m++) begin
                if (acc[m]) begin
                    n_tests++;
                    if ({ddram_address, ddram_burstcount, ddram_byteenable, ddram_write, ddram_read} !==
                        {m_addr[m], m_bc[m], m_be[m], m_write[m], m_read[m]}) begin
                        n_fail++; $display("FAIL rnd_cmd_fwd: got addr=%h bc=%0d be=%h want %h %0d %h (master %0d)",
                            ddram_address, ddram_burstcount, ddram_byteenable, m_addr[m], m_bc[m], m_be[m], m);
                    end
                    n_tests++;
                    if (wr_owner != -1 && wr_owner != m) begin
                        n_fail++; $display("FAIL rnd_write_atomic: got master %0d want %0d", m, wr_owner);
                    end
                    if (is_wr[m]) begin
                        n_tests++;
                        if (ddram_writedata !== m_wdata[m]) begin
                            n_fail++; $display("FAIL rnd_wdata: got %h want %h", ddram_writedata, m_wdata[m]);
                        end
                        pend[m]--;
                        wr_owner   = (pend[m] == 0) ? -1 : m;
                        m_wdata[m] = {$urandom, $urandom};
                    end else begin
                        n_tests++;
                        if (q_len.size() >= DEPTH) begin
                            n_fail++; $display("FAIL rnd_fifo_limit: got %0d outstanding want <%0d", q_len.size(), DEPTH);
                        end
                        q_len.push_back(pend[m]);
                        q_own.push_back(m);
                        pend[m] = 0;
                    end
                end
            end
            if (rv) begin
                own = q_own[0];
                n_tests++;
                if ({b_readdatavalid, a_readdatavalid} !== ((own == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL rnd_return_owner: got vb/va %b want owner %0d", {b_readdatavalid, a_readdatavalid}, own);
                end
                n_tests++;
                if (a_readdata !== rd || b_readdata !== rd) begin
                    n_fail++; $display("FAIL rnd_rdata: got %h/%h want %h", a_readdata, b_readdata, rd);
                end
                head_done++;
                if (head_done == q_len[0]) begin
                    void'(q_len.pop_front());
                    void'(q_own.pop_front());
                    head_done = 0;
                end
            end else begin
                n_tests++;
                if ({b_readdatavalid, a_readdatavalid} !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_spurious_valid: got %b want 00", {b_readdatavalid, a_readdatavalid});
                end
            end
            @(negedge clk_sys);
            done = (c >= 2000) && pend[0] == 0 && pend[1] == 0 && q_len.size() == 0;
        end
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL rnd_drain: got pend=%0d/%0d outstanding=%0d want all zero", pend[0], pend[1], q_len.size());
        end
        n_tests++;
        if (err_orphan !== 1'b0) begin
            n_fail++; $display("FAIL rnd_no_orphan: got %b want 0", err_orphan);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk_sys);
        test_reset();
        test_single_read();
        test_orphan();
        test_round_robin();
        test_atomic_write();
        test_fifo_full();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
